hbm_avmm_channel_model: RTL and testbench
=========================================

# hbm_avmm_channel_model

Behavioural, synthesizable model of one HBM2 pseudo-channel as seen from the fabric side: an Avalon-MM slave with 256-bit data, a calibration-status handshake, and an on-chip word array. It replaces the controller plus external memory model in system-level simulation. Avalon-MM BFM masters use it to run write/read-back checks without the vendor IP.

## Interface
Parameters:
- `DATA_WIDTH`, 256: data bus width in bits; byte-enable width is `DATA_WIDTH/8`.
- `ADDR_WIDTH`, 64: byte address width.
- `DEPTH_WORDS`, 1024: number of 256-bit words stored; power of two.
- `BURST_WIDTH`, 7: `avs_burstcount` width.
- `CAL_CYCLES`, 64: clocks from reset release to calibration success.
- `READ_LATENCY`, 8: cycles from read-beat issue to `avs_readdatavalid`; ≥2.

Ports:
- `clk`, in, 1: sole clock.
- `reset_n`, in, 1: reset; one clock; reset is asynchronous and active-low.
- `avs_address`, in, ADDR_WIDTH: byte address, 32-byte aligned.
- `avs_read`, in, 1: read request.
- `avs_write`, in, 1: write request / write beat.
- `avs_writedata`, in, DATA_WIDTH: write data.
- `avs_byteenable`, in, DATA_WIDTH/8: per-byte write enable.
- `avs_burstcount`, in, BURST_WIDTH: beats per burst; 0 is treated as 1.
- `avs_waitrequest`, out, 1: high means the command/beat is not accepted.
- `avs_readdata`, out, DATA_WIDTH: read data.
- `avs_readdatavalid`, out, 1: `avs_readdata` valid this cycle.
- `local_cal_success`, out, 1: calibration done; sticky until reset.
- `local_cal_fail`, out, 1: constant 0.

## Operation
- **Reset values.**
  - `avs_waitrequest` is 1; `avs_readdatavalid`, `local_cal_success` and `local_cal_fail` are 0; `avs_readdata` is 0.
  - Read pipeline and burst state are cleared; the calibration counter is cleared.
  - Array contents are not reset and are retained across reset; power-up contents are unspecified.
- **Calibration.**
  - The counter increments each clock after reset deassertion.
  - At count `CAL_CYCLES`, `local_cal_success` goes to 1 and stays 1.
  - Until then `avs_waitrequest` is 1.
- **Address decode.**
  - Word index = `avs_address[5 +: log2(DEPTH_WORDS)]`.
  - Bits [4:0] are ignored.
  - Upper bits are ignored, so the address space aliases modulo `DEPTH_WORDS*32` bytes.
- **Write.**
  - A beat is accepted when `avs_write` is high and `avs_waitrequest` is low.
  - The first beat latches the word index and burstcount.
  - Beat k writes index+k, wrapping modulo `DEPTH_WORDS`.
  - Byte i is updated only when `avs_byteenable[i]` is 1.
  - The write is committed at the accepting clock edge.
  - During a write burst, `avs_address`, `avs_burstcount` and `avs_read` are ignored until the last beat.
- **Read.**
  - A read is accepted when `avs_read` is high, `avs_waitrequest` is low, and no write burst is in progress.
  - The burst generator issues one beat per cycle, starting in the accept cycle, at index, index+1, and so on (wrapping).
  - Each beat is sampled from the array at issue and delivered through a `READ_LATENCY` pipeline.
  - `avs_waitrequest` stays high while the generator still has beats to issue, i.e. for burstcount−1 cycles after accept.
  - Data return strictly in issue order.
- **Simultaneous `avs_read` and `avs_write`.** Write wins and the read is dropped.
- **Hazards.** A read issued after a write commit returns the written data. There is no read-before-write reordering.

## Timing
- `avs_waitrequest` is combinational from state: 1 when not calibrated, or when the read generator is busy; otherwise 0.
- Single read accepted at edge T: `avs_readdatavalid` = 1 in the cycle after edge T+READ_LATENCY−1, i.e. exactly READ_LATENCY cycles later, high for one cycle.
- Burst of N: valid on N consecutive cycles.
- Back-to-back single reads: one per cycle, with no bubbles.
- Writes: one beat per cycle, zero wait states once calibrated.
- `reset_n` asserted mid-burst:
  - In-flight read data are discarded.
  - `avs_readdatavalid` drops asynchronously.
  - Calibration restarts.
  - A partial write burst is abandoned; beats already committed remain in the array.

## Test plan
- **Calibration gate.** Release reset and hold `avs_write`=1 → `avs_waitrequest`=1 for exactly CAL_CYCLES clocks, then `local_cal_success`=1 and the write is accepted. `local_cal_fail` stays 0.
- **Write/read-back.** Write 16 single beats, data {8{i}} (32-bit i replicated), at address i*32, byteenable all-ones. Then push 16 pipelined reads at i*32 → 16 `avs_readdatavalid` pulses on consecutive cycles, data {8{i}} in order, first pulse READ_LATENCY cycles after the first accept.
- **Byte-enable merge.**
  - Write all-ones to 0x40.
  - Write 0 with byteenable 0x0000FFFF.
  - Read 0x40 → upper 128 bits all-ones, lower 128 bits 0.
- **Bursts.**
  - Write burst of 4 at 0x100 with data 1..4.
  - Read burst of 4 at 0x100 → `avs_waitrequest` high for 3 cycles after accept; data 1,2,3,4 on 4 consecutive cycles.
- **Aliasing.** Write 0xAA.. at 0, read `DEPTH_WORDS*32` → returns 0xAA..
- **Reset mid-read.**
  - Issue a read burst of 8 and assert `reset_n` low after 2 data beats → `avs_readdatavalid` 0 immediately, no further beats.
  - After recalibration, earlier written data are still readable.

Source files
------------

// File: rtl/hbm_avmm_channel_model.sv
// ============================================================================
// Module   : hbm_avmm_channel_model
// Purpose  : Behavioural HBM2 pseudo-channel. Avalon-MM slave in front of an
//            on-chip word array, gated by a calibration countdown.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hbm_avmm_channel_model #(
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 64,
  parameter int DEPTH_WORDS  = 1024,
  parameter int BURST_WIDTH  = 7,
  parameter int CAL_CYCLES   = 64,
  parameter int READ_LATENCY = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_WIDTH-1:0]     avs_address,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [DATA_WIDTH-1:0]     avs_writedata,
  input  logic [DATA_WIDTH/8-1:0]   avs_byteenable,
  input  logic [BURST_WIDTH-1:0]    avs_burstcount,
  output logic                      avs_waitrequest,
  output logic [DATA_WIDTH-1:0]     avs_readdata,
  output logic                      avs_readdatavalid,
  output logic                      local_cal_success,
  output logic                      local_cal_fail
);

  localparam int c_BE_W  = DATA_WIDTH / 8;
  localparam int c_IDX_W = $clog2(DEPTH_WORDS);
  localparam int c_CNT_W = $clog2(CAL_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CAL_LAST = c_CNT_W'(CAL_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_CAL = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     w_cal_inc;
  logic [c_CNT_W-1:0]       r_cal_cnt;

  logic [DATA_WIDTH-1:0]    r_mem [DEPTH_WORDS];

  logic                     r_wr_busy;
  logic [c_IDX_W-1:0]       r_wr_idx;
  logic [BURST_WIDTH-1:0]   r_wr_left;
  logic                     r_rd_busy;
  logic [c_IDX_W-1:0]       r_rd_idx;
  logic [BURST_WIDTH-1:0]   r_rd_left;

  logic [READ_LATENCY-1:0]  r_pipe_vld;
  logic [DATA_WIDTH-1:0]    r_pipe_data [READ_LATENCY];

  logic                     w_wr_acc;
  logic                     w_rd_acc;
  logic                     w_rd_issue;
  logic [BURST_WIDTH-1:0]   w_bc;
  logic [c_IDX_W-1:0]       w_addr_idx;
  logic [c_IDX_W-1:0]       w_wr_idx;
  logic [c_IDX_W-1:0]       w_rd_idx;
  logic                     w_unused_addr;

  // Calibration FSM: counts clocks after reset release, then stays in RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_CAL;
      r_cal_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cal_inc) r_cal_cnt <= r_cal_cnt + c_CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cal_inc   = 1'b0;
    case (r_state)
      ST_CAL: begin
        w_cal_inc = 1'b1;
        if (r_cal_cnt == c_CAL_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_CAL;
    endcase
  end

  assign local_cal_success = (r_state == ST_RUN);
  assign local_cal_fail    = 1'b0;
  assign avs_waitrequest   = (r_state != ST_RUN) || r_rd_busy;

  assign w_bc          = (avs_burstcount == '0) ? BURST_WIDTH'(1) : avs_burstcount;
  assign w_addr_idx    = avs_address[5 +: c_IDX_W];
  assign w_unused_addr = ^{avs_address[4:0], avs_address[ADDR_WIDTH-1:5+c_IDX_W]};

  assign w_wr_acc   = avs_write && !avs_waitrequest;
  assign w_rd_acc   = avs_read && !avs_write && !avs_waitrequest && !r_wr_busy;
  assign w_rd_issue = w_rd_acc || r_rd_busy;
  assign w_wr_idx   = r_wr_busy ? r_wr_idx : w_addr_idx;
  assign w_rd_idx   = r_rd_busy ? r_rd_idx : w_addr_idx;

  // Burst trackers: *_left counts beats still owed, including the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_busy <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_left <= '0;
      r_rd_busy <= 1'b0;
      r_rd_idx  <= '0;
      r_rd_left <= '0;
    end else begin
      if (w_wr_acc) begin
        if (!r_wr_busy) begin
          if (w_bc != BURST_WIDTH'(1)) begin
            r_wr_busy <= 1'b1;
            r_wr_idx  <= w_addr_idx + c_IDX_W'(1);
            r_wr_left <= w_bc - BURST_WIDTH'(1);
          end
        end else begin
          r_wr_idx  <= r_wr_idx + c_IDX_W'(1);
          r_wr_left <= r_wr_left - BURST_WIDTH'(1);
          if (r_wr_left == BURST_WIDTH'(1)) r_wr_busy <= 1'b0;
        end
      end
      if (w_rd_acc) begin
        if (w_bc != BURST_WIDTH'(1)) begin
          r_rd_busy <= 1'b1;
          r_rd_idx  <= w_addr_idx + c_IDX_W'(1);
          r_rd_left <= w_bc - BURST_WIDTH'(1);
        end
      end else if (r_rd_busy) begin
        r_rd_idx  <= r_rd_idx + c_IDX_W'(1);
        r_rd_left <= r_rd_left - BURST_WIDTH'(1);
        if (r_rd_left == BURST_WIDTH'(1)) r_rd_busy <= 1'b0;
      end
    end
  end

  // Array has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      for (int b = 0; b < c_BE_W; b++) begin
        if (avs_byteenable[b]) r_mem[w_wr_idx][b*8 +: 8] <= avs_writedata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_pipe_data[i] <= '0;
    end else begin
      r_pipe_vld <= {r_pipe_vld[READ_LATENCY-2:0], w_rd_issue};
      if (w_rd_issue) r_pipe_data[0] <= r_mem[w_rd_idx];
      for (int i = 1; i < READ_LATENCY; i++) r_pipe_data[i] <= r_pipe_data[i-1];
    end
  end

  assign avs_readdatavalid = r_pipe_vld[READ_LATENCY-1];
  assign avs_readdata      = r_pipe_data[READ_LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_hbm_avmm_channel_model.sv
// ============================================================================
// Module   : tb_hbm_avmm_channel_model
// Purpose  : Scoreboard bench for hbm_avmm_channel_model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hbm_avmm_channel_model;

  localparam int DW    = 256;
  localparam int AW    = 64;
  localparam int DEPTH = 1024;
  localparam int IW    = 10;
  localparam int BW    = 7;
  localparam int CAL   = 64;
  localparam int LAT   = 8;
  localparam int TMO   = 200;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [AW-1:0]     avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DW-1:0]     avs_writedata;
  logic [DW/8-1:0]   avs_byteenable;
  logic [BW-1:0]     avs_burstcount;
  logic              avs_waitrequest;
  logic [DW-1:0]     avs_readdata;
  logic              avs_readdatavalid;
  logic              local_cal_success;
  logic              local_cal_fail;

  hbm_avmm_channel_model #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH),
    .BURST_WIDTH(BW), .CAL_CYCLES(CAL), .READ_LATENCY(LAT)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_byteenable(avs_byteenable), .avs_burstcount(avs_burstcount),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .local_cal_success(local_cal_success),
    .local_cal_fail(local_cal_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] wq[$];
  logic [DW-1:0] m_mem [DEPTH];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_rx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (avs_readdatavalid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rd_unexpected", DW'(avs_readdatavalid), '0);
      end else begin : pop_blk
        exp_t e;
        e = sb.pop_front();
        chk("rd_data", avs_readdata, e.d);
        chk("rd_cycle", DW'(cyc), DW'(e.c));
        n_rx++;
      end
    end
  end

  // Waits for the current command/beat to be accepted; returns #1 after that edge.
  task automatic step_accept(input string tag);
    int   n;
    logic w;
    n = 0;
    forever begin
      w = avs_waitrequest;
      @(posedge clk); #1;
      if (!w) break;
      n++;
      if (n > TMO) begin
        chk({tag, "_timeout"}, DW'(n), DW'(TMO));
        break;
      end
    end
  endtask

  task automatic wr_burst(input logic [AW-1:0] addr, input int n, input logic [DW/8-1:0] be);
    int            idx;
    logic [DW-1:0] d;
    idx            = int'(addr[5 +: IW]);
    avs_write      = 1'b1;
    avs_address    = addr;
    avs_burstcount = BW'(n);
    avs_byteenable = be;
    for (int k = 0; k < n; k++) begin
      d             = wq.pop_front();
      avs_writedata = d;
      step_accept("wr_accept");
      for (int b = 0; b < DW/8; b++)
        if (be[b]) m_mem[(idx + k) % DEPTH][b*8 +: 8] = d[b*8 +: 8];
      // Later beats carry junk address/count that must be ignored.
      avs_address    = '0;
      avs_burstcount = BW'(1);
    end
    avs_write = 1'b0;
  endtask

  task automatic rd_burst(input logic [AW-1:0] addr, input int n, input bit hold);
    int idx;
    int t;
    idx            = int'(addr[5 +: IW]);
    avs_read       = 1'b1;
    avs_address    = addr;
    avs_burstcount = BW'(n);
    step_accept("rd_accept");
    t = cyc;
    for (int k = 0; k < n; k++) sb.push_back('{m_mem[(idx + k) % DEPTH], t + LAT - 1 + k});
    if (!hold) avs_read = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", DW'(sb.size()), '0);
    sb.delete();
  endtask

  task automatic wait_cal(input string tag);
    int cnt;
    cnt = 0;
    while (avs_waitrequest && cnt < TMO) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk(tag, DW'(cnt), DW'(CAL));
    chk({tag, "_success"}, DW'(local_cal_success), DW'(1));
    chk({tag, "_fail"}, DW'(local_cal_fail), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int rx0;
    reset_n        = 1'b0;
    avs_address    = '0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = '0;
    avs_byteenable = '1;
    avs_burstcount = BW'(1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_waitreq", DW'(avs_waitrequest), DW'(1));
    chk("rst_rdvalid", DW'(avs_readdatavalid), '0);
    chk("rst_rddata", avs_readdata, '0);
    chk("rst_cal_success", DW'(local_cal_success), '0);
    chk("rst_cal_fail", DW'(local_cal_fail), '0);

    // Calibration gate with a write held pending.
    wq.push_back({8{32'hCA1CA1}});
    avs_write     = 1'b1;
    avs_address   = 64'h3FE0;
    avs_writedata = {8{32'hCA1CA1}};
    reset_n       = 1'b1;
    wait_cal("cal_wait_cycles");
    avs_write = 1'b0;
    wr_burst(64'h3FE0, 1, '1);

    // Write/read-back, pipelined single reads.
    for (int i = 0; i < 16; i++) begin
      wq.push_back({8{32'(i)}});
      wr_burst(AW'(i * 32), 1, '1);
    end
    for (int i = 0; i < 16; i++) rd_burst(AW'(i * 32), 1, i != 15);
    drain();
    rd_burst(64'h3FE0, 1, 1'b0);
    drain();

    // Byte-enable merge.
    wq.push_back('1);
    wr_burst(64'h40, 1, '1);
    wq.push_back('0);
    wr_burst(64'h40, 1, 32'h0000FFFF);
    rd_burst(64'h40, 1, 1'b0);
    drain();

    // Bursts of 4.
    for (int k = 1; k <= 4; k++) wq.push_back(DW'(k));
    wr_burst(64'h100, 4, '1);
    rd_burst(64'h100, 4, 1'b0);
    chk("burst_wait0", DW'(avs_waitrequest), DW'(1));
    @(posedge clk); #1;
    chk("burst_wait1", DW'(avs_waitrequest), DW'(1));
    @(posedge clk); #1;
    chk("burst_wait2", DW'(avs_waitrequest), DW'(1));
    @(posedge clk); #1;
    chk("burst_wait3", DW'(avs_waitrequest), '0);
    drain();

    // Aliasing across DEPTH_WORDS*32 bytes.
    wq.push_back({32{8'hAA}});
    wr_burst(64'h0, 1, '1);
    rd_burst(AW'(DEPTH * 32), 1, 1'b0);
    drain();

    // Reset in the middle of a read burst.
    for (int k = 0; k < 8; k++) wq.push_back({8{32'hB000 + 32'(k)}});
    wr_burst(64'h200, 8, '1);
    rx0 = n_rx;
    rd_burst(64'h200, 8, 1'b0);
    cnt = 0;
    while (n_rx < rx0 + 2 && cnt < TMO) begin
      @(negedge clk); #1;
      cnt++;
    end
    chk("mid_rx_beats", DW'(n_rx - rx0), DW'(2));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rdvalid", DW'(avs_readdatavalid), '0);
    chk("mid_rst_waitreq", DW'(avs_waitrequest), DW'(1));
    sb.delete();
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("recal_success_low", DW'(local_cal_success), '0);
    wait_cal("recal_cycles");
    rd_burst(64'h200, 8, 1'b0);
    drain();
    rd_burst(64'h20, 1, 1'b0);
    rd_burst(64'h40, 1, 1'b0);
    drain();

    repeat (LAT + 2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
